// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) single-memory arbiter with locked bursts and registered read returns.
// Define ARB_ROUND_ROBIN_EN to resolve contention round-robin; otherwise port 0 always wins.
module mem_arbiter #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  // Port 0 (CPU)
  input  logic             c_req,
  input  logic             c_we,
  input  logic             c_lock,
  input  logic [DBITS-1:0] c_addr,
  input  logic [DBITS-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [DBITS-1:0] c_rdata,
  // Port 1 (DMA / debug)
  input  logic             d_req,
  input  logic             d_we,
  input  logic             d_lock,
  input  logic [DBITS-1:0] d_addr,
  input  logic [DBITS-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DBITS-1:0] d_rdata,
  // Memory side
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  // burst_q counts held grants beyond the first of a burst, so a burst spans MAX_BURST grants.
  localparam logic [3:0] BurstLimit = 4'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       c_rvalid_q, d_rvalid_q;
  logic       hold0, hold1;
  logic       gnt0, gnt1;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;  // port that wins the next contended cycle
`endif

  always_comb begin
    hold0 = (state_q == StOwn0) && c_req && c_lock && (burst_q < BurstLimit);
    hold1 = (state_q == StOwn1) && d_req && d_lock && (burst_q < BurstLimit);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!reset) begin
      if (hold0) begin
        gnt0 = 1'b1;
      end else if (hold1) begin
        gnt1 = 1'b1;
      end else if (c_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        gnt0 = ~rr_q;
        gnt1 = rr_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = c_req;
        gnt1 = d_req;
      end
    end
  end

  always_comb begin
    state_d = StIdle;
    if (gnt0) begin
      state_d = StOwn0;
    end else if (gnt1) begin
      state_d = StOwn1;
    end
    // Any grant that is not a lock hold starts a fresh burst.
    burst_d = ((gnt0 && hold0) || (gnt1 && hold1)) ? burst_q + 4'd1 : 4'd0;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    rr_d = rr_q;
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      burst_q    <= 4'd0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      c_rvalid_q <= gnt0 && !c_we;
      d_rvalid_q <= gnt1 && !d_we;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (gnt1) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Read returns are masked while reset is high so a read issued just before reset never surfaces.
  always_comb begin
    c_gnt    = gnt0;
    d_gnt    = gnt1;
    c_rvalid = c_rvalid_q && !reset;
    d_rvalid = d_rvalid_q && !reset;
    c_rdata  = c_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural grant/read-return model plus directed scenarios.
module tb_mem_arbiter;

  localparam int DBITS     = 32;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [DBITS-1:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
  logic             c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
  logic [DBITS-1:0] c_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DBITS(DBITS), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner (-1 none), grants so far in the current burst, favoured port, pending read port.
  int m_owner = -1, m_run = 0, m_fav = 0, m_pend = -1;
  int n_owner, n_run, n_fav, n_pend;

  task automatic chk(input string name, input logic [DBITS-1:0] act, input logic [DBITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit               rq[2], lk[2], wr[2];
    logic [DBITS-1:0] ad[2], wd[2];
    int               g;
    bit               held;
    rq[0] = (c_req === 1'b1); lk[0] = (c_lock === 1'b1); wr[0] = (c_we === 1'b1);
    rq[1] = (d_req === 1'b1); lk[1] = (d_lock === 1'b1); wr[1] = (d_we === 1'b1);
    ad[0] = c_addr; wd[0] = c_wdata; ad[1] = d_addr; wd[1] = d_wdata;
    g = -1;
    held = 1'b0;
    if (reset !== 1'b1) begin
      if (m_owner >= 0 && rq[m_owner] && lk[m_owner] && m_run < MAX_BURST) begin
        g = m_owner;
        held = 1'b1;
      end else if (rq[0] && rq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        g = m_fav;
`else
        g = 0;
`endif
      end else if (rq[0]) begin
        g = 0;
      end else if (rq[1]) begin
        g = 1;
      end
    end
    chk("c_gnt", DBITS'(c_gnt), DBITS'(g == 0));
    chk("d_gnt", DBITS'(d_gnt), DBITS'(g == 1));
    chk("mem_we", DBITS'(mem_we), (g >= 0) ? DBITS'(wr[g]) : '0);
    chk("mem_addr", mem_addr, (g >= 0) ? ad[g] : '0);
    chk("mem_wdata", mem_wdata, (g >= 0) ? wd[g] : '0);
    chk("c_rvalid", DBITS'(c_rvalid), DBITS'(reset !== 1'b1 && m_pend == 0));
    chk("d_rvalid", DBITS'(d_rvalid), DBITS'(reset !== 1'b1 && m_pend == 1));
    chk("c_rdata", c_rdata, (reset !== 1'b1 && m_pend == 0) ? mem_rdata : '0);
    chk("d_rdata", d_rdata, (reset !== 1'b1 && m_pend == 1) ? mem_rdata : '0);
    if (reset === 1'b1) begin
      n_owner = -1; n_run = 0; n_fav = 0; n_pend = -1;
    end else begin
      n_owner = g;
      n_run   = held ? m_run + 1 : ((g >= 0) ? 1 : 0);
      n_fav   = (g >= 0) ? 1 - g : m_fav;
      n_pend  = (g >= 0 && !wr[g]) ? g : -1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_next();
    @(posedge clk);
    m_owner = n_owner; m_run = n_run; m_fav = n_fav; m_pend = n_pend;
    #1;
  endtask

  task automatic tick();
    at_neg();
    to_next();
  endtask

  task automatic quiet();
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    c_req = 1; d_req = 1; c_addr = 32'h55; d_addr = 32'hAA;
    at_neg();
    chk("rst_c_gnt", DBITS'(c_gnt), '0);
    chk("rst_mem_addr", mem_addr, '0);
    to_next();
    quiet();
    do_reset();

    // Single read with data returned the following cycle
    c_req = 1; c_addr = 32'h100;
    at_neg();
    chk("s033_c_gnt", DBITS'(c_gnt), 1);
    chk("s033_mem_addr", mem_addr, 32'h100);
    to_next();
    quiet();
    mem_rdata = 32'hDEADBEEF;
    at_neg();
    chk("s033_c_rvalid", DBITS'(c_rvalid), 1);
    chk("s033_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("s033_d_rvalid", DBITS'(d_rvalid), 0);
    to_next();

    // Both ports contend with unlocked reads
    do_reset();
    c_req = 1; d_req = 1; c_addr = 32'h10; d_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = $urandom;
      at_neg();
`ifdef ARB_ROUND_ROBIN_EN
      chk("s034_c_gnt", DBITS'(c_gnt), DBITS'(i % 2 == 0));
      chk("s034_d_gnt", DBITS'(d_gnt), DBITS'(i % 2 == 1));
      if (i > 0) chk("s034_c_rvalid", DBITS'(c_rvalid), DBITS'(i % 2 == 1));
`else
      chk("s038_c_gnt", DBITS'(c_gnt), 1);
      chk("s038_d_gnt", DBITS'(d_gnt), 0);
      if (i > 0) chk("s038_c_rvalid", DBITS'(c_rvalid), 1);
`endif
      to_next();
    end
    quiet();
    tick();

    // Locked burst from port 1 while port 0 waits
    do_reset();
    d_req = 1; d_lock = 1; d_addr = 32'h300;
    at_neg();
    chk("s035_d_gnt0", DBITS'(d_gnt), 1);
    to_next();
    c_req = 1; c_addr = 32'h400;
    for (int i = 1; i <= 4; i++) begin
      at_neg();
      chk("s035_d_gnt", DBITS'(d_gnt), DBITS'(i < 4));
      chk("s035_c_gnt", DBITS'(c_gnt), DBITS'(i == 4));
      to_next();
    end
    quiet();
    tick();

    // Write: no read return
    c_req = 1; c_we = 1; c_addr = 32'hF0000000; c_wdata = 32'h1234;
    at_neg();
    chk("s036_mem_we", DBITS'(mem_we), 1);
    chk("s036_mem_addr", mem_addr, 32'hF0000000);
    chk("s036_mem_wdata", mem_wdata, 32'h1234);
    to_next();
    quiet();
    at_neg();
    chk("s036_c_rvalid", DBITS'(c_rvalid), 0);
    chk("s036_mem_we_off", DBITS'(mem_we), 0);
    to_next();

    // Read immediately followed by reset
    c_req = 1; c_addr = 32'h77;
    at_neg();
    chk("s037_c_gnt", DBITS'(c_gnt), 1);
    to_next();
    reset = 1; c_req = 1; d_req = 1;
    at_neg();
    chk("s037_c_rvalid_rst", DBITS'(c_rvalid), 0);
    chk("s037_c_gnt_rst", DBITS'(c_gnt), 0);
    chk("s037_mem_addr_rst", mem_addr, 0);
    to_next();
    reset = 0;
    at_neg();
    chk("s037_c_rvalid_post", DBITS'(c_rvalid), 0);
    chk("s037_c_gnt_post", DBITS'(c_gnt), 1);
    to_next();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      c_req   = ($urandom_range(0, 3) != 0);
      c_lock  = ($urandom_range(0, 3) != 0);
      c_we    = ($urandom_range(0, 2) == 0);
      c_addr  = $urandom;
      c_wdata = $urandom;
      d_req   = ($urandom_range(0, 3) != 0);
      d_lock  = ($urandom_range(0, 3) != 0);
      d_we    = ($urandom_range(0, 2) == 0);
      d_addr  = $urandom;
      d_wdata = $urandom;
      mem_rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DBITS, default 32, meaning the address and data width.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive locked grants to one port, legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have the port-0 (CPU) request inputs: c_req 1, c_we 1, c_lock 1, c_addr DBITS, c_wdata DBITS.
REQ-006 The block SHALL have the port-0 (CPU) outputs: c_gnt 1, c_rvalid 1, c_rdata DBITS.
REQ-007 The block SHALL have the port-1 (DMA/debug) request inputs: d_req 1, d_we 1, d_lock 1, d_addr DBITS, d_wdata DBITS.
REQ-008 The block SHALL have the port-1 (DMA/debug) outputs: d_gnt 1, d_rvalid 1, d_rdata DBITS.
REQ-009 The block SHALL have the memory-side outputs: mem_we 1, mem_addr DBITS, mem_wdata DBITS.
REQ-010 The block SHALL have the memory-side input mem_rdata, DBITS: valid one cycle after the address is presented.

Function
REQ-011 c_gnt and d_gnt SHALL be combinational, never both high, and each high only while its own req is high.
REQ-012 A grant SHALL mean the access is issued this cycle: mem_addr and mem_wdata come from the granted port, and mem_we = granted we.
REQ-013 With no grant, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-014 The FSM SHALL have three states: IDLE (no owner), OWN0 and OWN1.
REQ-015 In any state, when the owner is not eligible to hold, arbitration SHALL apply:
- only one req high: that port is granted;
- both high: the port not served last (rr_ptr) is granted.
REQ-016 The owner SHALL be eligible to hold when owner req and owner lock are high and burst_cnt < MAX_BURST-1; it is then granted regardless of the other req.
REQ-017 The next state SHALL be OWNx when port x is granted this cycle, and IDLE when no grant is made.
REQ-018 burst_cnt (4 bits) SHALL increment on each held grant and clear on an ownership change, on a grant with lock low, or in IDLE.
REQ-019 rr_ptr SHALL update on every grant to point at the non-granted port.
REQ-020 A grant with we=0 SHALL set that port's rvalid high for exactly the next cycle, with rdata = mem_rdata in that cycle.
REQ-021 In all other cycles rdata SHALL be 0.
REQ-022 A grant with we=1 SHALL produce no rvalid.
REQ-023 Back-to-back reads SHALL produce back-to-back rvalids, including across an ownership change; throughput is one access per cycle.
REQ-024 A req dropped while ungranted SHALL be discarded, with no state effect.
REQ-025 When MAX_BURST=1, lock SHALL have no effect.

Reset
REQ-026 While reset is high, c_gnt, d_gnt, mem_we, c_rvalid and d_rvalid SHALL be 0, and mem_addr, mem_wdata, c_rdata and d_rdata SHALL be 0.
REQ-027 On the clock edge with reset high, the FSM SHALL go to IDLE, rr_ptr SHALL be set to favour port 0, and burst_cnt SHALL be cleared.
REQ-028 A read granted in the cycle before reset SHALL NOT produce an rvalid after reset.
REQ-029 The first grant SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: contention SHALL be resolved by rr_ptr per REQ-015.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: port 0 SHALL always win contention, and rr_ptr logic SHALL be absent.
REQ-032 Locked holding per REQ-016 SHALL behave identically in both builds.

Verification
REQ-033 Scenario: reset, then c_req=1, c_we=0, c_addr=0x100, with mem_rdata=0xDEADBEEF the next cycle -> c_gnt=1 and mem_addr=0x100 in cycle 0; c_rvalid=1 and c_rdata=0xDEADBEEF in cycle 1; d_rvalid=0.
REQ-034 Scenario: both ports request unlocked reads for 4 cycles (round robin enabled) -> grants alternate C, D, C, D, and rvalids alternate one cycle later.
REQ-035 Scenario: d_req=1, d_lock=1, MAX_BURST=4, with c_req=1 throughout -> d_gnt for 4 consecutive cycles, then c_gnt in cycle 5.
REQ-036 Scenario: c_req=1, c_we=1, c_addr=0xF0000000, c_wdata=0x1234 -> mem_we=1 with matching address and data for one cycle; no c_rvalid.
REQ-037 Scenario: a read is granted, then reset is asserted the next cycle -> c_rvalid=0, all outputs 0, and the FSM is in IDLE.
REQ-038 Scenario: round robin disabled, both ports request continuously and unlocked -> c_gnt every cycle and d_gnt never.
